// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types, funct3 codes and memory geometry for the data-memory controller
package dmem_ctrl_pkg;
  localparam int MEM_WORDS = 1024;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_WR     = 3'd4,
    S_DONE   = 3'd5
  } state_t;
  function automatic logic is_legal_f3(input logic [2:0] f3);
    return f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte/half lane extraction with extension for loads, and lane merge for stores
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bmask, hmask;
  always_comb begin
    b = lane == 2'd0 ? word[7:0] : lane == 2'd1 ? word[15:8] : lane == 2'd2 ? word[23:16] : word[31:24];
    h = lane[1] ? word[31:16] : word[15:0];
    ld_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
              funct3 == F3_BU ? {24'b0, b} :
              funct3 == F3_H  ? {{16{h[15]}}, h} :
              funct3 == F3_HU ? {16'b0, h} : word;
    bmask = 32'h0000_00FF << {lane, 3'b000};
    hmask = 32'h0000_FFFF << {lane[1], 4'b0000};
    merged = funct3[1:0] == 2'b00 ? (old_word & ~bmask) | ({4{wdata[7:0]}} & bmask) :
             funct3[1:0] == 2'b01 ? (old_word & ~hmask) | ({2{wdata[15:0]}} & hmask) : wdata;
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences RV32I loads/stores onto a word-only data memory, using
// read-modify-write for sub-word stores and rejecting illegal, misaligned or out-of-range requests
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write
);
  state_t state, state_n, acc_state;
  logic acc, acc_err, err_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0] f3_q;
  logic [1:0] lane_q;
  logic [31:0] wdata_q, old_q, rdata_q, ld_data, merged;
  assign cpu_ready = state == S_IDLE || state == S_DONE;
  assign acc = cpu_req & cpu_ready;
  always_comb begin
    acc_err = !is_legal_f3(cpu_funct3) || (cpu_we && cpu_funct3[2]) ||
              (cpu_funct3[1:0] == 2'b01 && cpu_addr[0]) ||
              (cpu_funct3[1:0] == 2'b10 && cpu_addr[1:0] != 2'b00) ||
              cpu_addr[31:IDX_W+2] != '0;
    acc_state = acc_err ? S_DONE : !cpu_we ? S_RD : cpu_funct3 == F3_W ? S_WR : S_RMW_RD;
    state_n = acc ? acc_state :
              state == S_RMW_RD ? S_RMW_WR :
              (state == S_RD || state == S_WR || state == S_RMW_WR) ? S_DONE : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx_q   <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      old_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        idx_q   <= cpu_addr[IDX_W+1:2];
        f3_q    <= cpu_funct3;
        lane_q  <= cpu_addr[1:0];
        wdata_q <= cpu_wdata;
        err_q   <= acc_err;
      end
      if (state == S_RMW_RD) old_q <= mem_rdata;
      if (state == S_RD) rdata_q <= ld_data;
    end
  end
  dmem_lane_align u_align (
    .word    (mem_rdata),
    .old_word(old_q),
    .wdata   (wdata_q),
    .lane    (lane_q),
    .funct3  (f3_q),
    .ld_data (ld_data),
    .merged  (merged)
  );
  assign cpu_busy  = (cpu_req & ~acc) | ~cpu_ready;
  assign cpu_done  = state == S_DONE;
  assign cpu_err   = cpu_done & err_q;
  assign cpu_rdata = rdata_q;
  assign mem_addr  = {{(32-IDX_W){1'b0}}, idx_q};
  assign mem_read  = state == S_RD || state == S_RMW_RD;
  assign mem_write = state == S_WR || state == S_RMW_WR;
  assign mem_wdata = mem_write ? merged : '0;
endmodule
